// File: rtl/fracturable_logic_cell_if.sv
// -----------------------------------------------------------------------------
// fracturable_logic_cell_if
// Purpose : bundles the user-logic and configuration-chain signals of one
//           fracturable logic cell so that the cell and its driver connect
//           through a single port.
// Ports   : enable, data_in[K-1:0], carry_in, cfg_shift, cfg_in, cfg_commit
//           are driven by the master; data_out[1:0], carry_out and cfg_out
//           are driven by the cell (slave).
// -----------------------------------------------------------------------------
interface fracturable_logic_cell_if #(
  parameter int K = 4
);
  logic         enable;
  logic [K-1:0] data_in;
  logic [1:0]   data_out;
  logic         carry_in;
  logic         carry_out;
  logic         cfg_shift;
  logic         cfg_in;
  logic         cfg_out;
  logic         cfg_commit;

  modport master (
    output enable, data_in, carry_in, cfg_shift, cfg_in, cfg_commit,
    input  data_out, carry_out, cfg_out
  );

  modport slave (
    input  enable, data_in, carry_in, cfg_shift, cfg_in, cfg_commit,
    output data_out, carry_out, cfg_out
  );
endinterface

// File: rtl/fracturable_logic_cell.sv
// -----------------------------------------------------------------------------
// fracturable_logic_cell
// Purpose : K-input LUT that can be fractured into two (K-1)-input LUTs,
//           with two user flip-flops, per-output comb/registered selection,
//           and a serial shadow/active configuration chain.
// Ports   : clock   - rising-edge clock
//           nreset  - synchronous, active-low reset
//           bus     - fracturable_logic_cell_if.slave (enable, data_in,
//                     data_out, carry_in, carry_out, cfg_shift, cfg_in,
//                     cfg_out, cfg_commit)
// Config  : define LOGIC_CELL_CARRY_EN to build the carry chain. Without it
//           the CARRY config bit is stored but has no effect, carry_out is 0
//           and carry_in is ignored. Port list and CFG_W do not change.
// Frame   : {CARRY, INIT, COMB_B, COMB_A, FRAC, T[2**K-1:0]}, shifted LSB first.
// -----------------------------------------------------------------------------
module fracturable_logic_cell #(
  parameter int K = 4
) (
  input  logic                          clock,
  input  logic                          nreset,
  fracturable_logic_cell_if.slave       bus
);

  localparam int TT         = 2 ** K;
  localparam int HALF       = 2 ** (K - 1);
  localparam int CFG_W      = TT + 5;
  localparam int IDX_FRAC   = TT;
  localparam int IDX_COMB_A = TT + 1;
  localparam int IDX_COMB_B = TT + 2;
  localparam int IDX_INIT   = TT + 3;
  localparam int IDX_CARRY  = TT + 4;

  logic [CFG_W-1:0] r_shadow;
  logic [CFG_W-1:0] r_active;
  logic             r_qa;
  logic             r_qb;

  logic [TT-1:0]    w_truth;
  logic [HALF-1:0]  w_truth_lo;
  logic [HALF-1:0]  w_truth_hi;
  logic [K-2:0]     w_lidx;
  logic             w_full;
  logic             w_lo;
  logic             w_hi;
  logic             w_frac;
  logic             w_carry_mode;
  logic             w_za;
  logic             w_zb;
  logic             w_carry_out;
  logic [1:0]       w_z;
  logic [1:0]       w_q;
  logic [1:0]       w_comb;

  // ---------------------------------------------------------------------------
  // Configuration chain and user flip-flops.
  // Commit copies the pre-edge shadow, so a shift in the same cycle only
  // affects the shadow. The FFs take INIT of the incoming frame on commit,
  // which therefore overrides enable.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_qa     <= 1'b0;
      r_qb     <= 1'b0;
    end else begin
      if (bus.cfg_shift) begin
        r_shadow <= {bus.cfg_in, r_shadow[CFG_W-1:1]};
      end
      if (bus.cfg_commit) begin
        r_active <= r_shadow;
        r_qa     <= r_shadow[IDX_INIT];
        r_qb     <= r_shadow[IDX_INIT];
      end else if (bus.enable) begin
        r_qa     <= w_za;
        r_qb     <= w_zb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LUT read paths (purely combinational)
  // ---------------------------------------------------------------------------
  assign w_truth    = r_active[TT-1:0];
  assign w_truth_lo = w_truth[HALF-1:0];
  assign w_truth_hi = w_truth[TT-1:HALF];
  assign w_lidx     = bus.data_in[K-2:0];
  assign w_full     = w_truth[bus.data_in];
  assign w_lo       = w_truth_lo[w_lidx];
  assign w_hi       = w_truth_hi[w_lidx];

`ifdef LOGIC_CELL_CARRY_EN
  // Carry mode forces the fractured split: the lower half acts as the
  // propagate function p, the sum is p ^ carry_in, and when p is 0 the
  // carry is generated from the otherwise-unused top LUT input.
  assign w_carry_mode = r_active[IDX_CARRY];
  assign w_frac       = r_active[IDX_FRAC] | w_carry_mode;
  assign w_carry_out  = w_carry_mode ? (w_lo ? bus.carry_in : bus.data_in[K-1]) : 1'b0;
`else
  // CARRY is held in the frame but has no effect in this build.
  logic w_unused_carry;
  assign w_unused_carry = bus.carry_in ^ r_active[IDX_CARRY];
  assign w_carry_mode   = 1'b0;
  assign w_frac         = r_active[IDX_FRAC];
  assign w_carry_out    = 1'b0;
`endif

  always_comb begin
    w_za = w_full;
    w_zb = w_full;
    if (w_frac) begin
      w_za = w_carry_mode ? (w_lo ^ bus.carry_in) : w_lo;
      w_zb = w_hi;
    end
  end

  assign bus.carry_out = w_carry_out;
  assign bus.cfg_out   = r_shadow[0];

  // ---------------------------------------------------------------------------
  // Per-output comb/registered select
  // ---------------------------------------------------------------------------
  assign w_z    = {w_zb, w_za};
  assign w_q    = {r_qb, r_qa};
  assign w_comb = {r_active[IDX_COMB_B], r_active[IDX_COMB_A]};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_out
      assign bus.data_out[gi] = w_comb[gi] ? w_z[gi] : w_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_fracturable_logic_cell.sv
// -----------------------------------------------------------------------------
// tb_fracturable_logic_cell
// Purpose : directed self-checking bench for fracturable_logic_cell, K=4.
//           Build with or without LOGIC_CELL_CARRY_EN; expectations follow.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fracturable_logic_cell;

  localparam int K     = 4;
  localparam int CFG_W = 21;

  logic clock;
  logic nreset;
  int   n_tests;
  int   n_fail;

  fracturable_logic_cell_if #(.K(K)) bus ();

  fracturable_logic_cell #(.K(K)) dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Frame layout: {CARRY, INIT, COMB_B, COMB_A, FRAC, T[15:0]}
  function automatic logic [CFG_W-1:0] mk_frame(input logic carry, input logic init,
                                                 input logic comb_b, input logic comb_a,
                                                 input logic frac, input logic [15:0] t);
    return {carry, init, comb_b, comb_a, frac, t};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    bus.cfg_shift = 1'b1;
    bus.cfg_in    = b;
    tick();
    bus.cfg_shift = 1'b0;
    bus.cfg_in    = 1'b0;
  endtask

  task automatic commit();
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
  endtask

  task automatic load_frame(input logic [CFG_W-1:0] f);
    for (int i = 0; i < CFG_W; i++) shift_bit(f[i]);
    commit();
  endtask

  task automatic set_in(input logic [3:0] d, input logic cin);
    bus.data_in  = d;
    bus.carry_in = cin;
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
  endtask

  logic [CFG_W-1:0] frame;

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    nreset         = 1'b0;
    bus.enable     = 1'b0;
    bus.data_in    = '0;
    bus.carry_in   = 1'b0;
    bus.cfg_shift  = 1'b0;
    bus.cfg_in     = 1'b0;
    bus.cfg_commit = 1'b0;
    tick();
    tick();
    nreset = 1'b1;

    // Reset state
    check("rst_data_out", bus.data_out, 2'b00);
    check("rst_cfg_out", bus.cfg_out, 1'b0);
    check("rst_carry_out", bus.carry_out, 1'b0);

    // AND4 in comb mode on output A
    load_frame(mk_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8000));
    set_in(4'hF, 1'b0);
    check("and4_F", bus.data_out, 2'b01);
    set_in(4'hE, 1'b0);
    check("and4_E", bus.data_out, 2'b00);
    // Shifting without commit must not disturb the active function
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    set_in(4'hF, 1'b0);
    check("and4_F_after_shift", bus.data_out, 2'b01);

    // Registered path
    do_reset();
    load_frame(mk_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF));
    set_in(4'h5, 1'b0);
    tick();
    tick();
    check("reg_hold_en0", bus.data_out, 2'b00);
    bus.enable = 1'b1;
    tick();
    bus.enable = 1'b0;
    check("reg_after_en", bus.data_out, 2'b11);

    // Fractured mode: lower half = 8'hFF, upper half = 8'h00
    load_frame(mk_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00FF));
    set_in(4'h3, 1'b0);
    check("frac_3", bus.data_out, 2'b01);
    set_in(4'hB, 1'b0);
    check("frac_B", bus.data_out, 2'b01);

    // Commit beats enable; INIT loads both FFs
    frame = mk_frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < CFG_W; i++) shift_bit(frame[i]);
    set_in(4'h0, 1'b0);
    bus.enable = 1'b1;
    commit();
    bus.enable = 1'b0;
    check("commit_init_wins", bus.data_out, 2'b11);
    do_reset();
    check("reset_clears_q", bus.data_out, 2'b00);
    for (int i = 0; i < CFG_W; i++) begin
      shift_bit(1'b0);
      check($sformatf("rst_cfg_out_%0d", i), bus.cfg_out, 1'b0);
    end

    // Partial frame discarded by reset, then a full frame
    for (int i = 0; i < 10; i++) shift_bit(1'b1);
    do_reset();
    frame = mk_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hA5C3);
    for (int i = 0; i < CFG_W; i++) begin
      shift_bit(frame[i]);
      if (i < CFG_W - 1) check($sformatf("partial_cfg_out_%0d", i), bus.cfg_out, 1'b0);
    end
    commit();
    set_in(4'h0, 1'b0);
    check("newframe_0", bus.data_out, 2'b11);
    set_in(4'h2, 1'b0);
    check("newframe_2", bus.data_out, 2'b00);
    for (int i = 0; i < CFG_W; i++) begin
      check($sformatf("replay_%0d", i), bus.cfg_out, frame[i]);
      shift_bit(1'b0);
    end
    set_in(4'hF, 1'b0);
    check("newframe_F_after_replay", bus.data_out, 2'b11);

    // Carry: lower half = d0 ^ d1 (8'h66), upper half 0, CARRY=1, FRAC=0
    load_frame(mk_frame(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0066));
    set_in(4'b0001, 1'b1);
`ifdef LOGIC_CELL_CARRY_EN
    check("carry_101_out", bus.data_out, 2'b00);
    check("carry_101_cout", bus.carry_out, 1'b1);
`else
    check("carry_101_out", bus.data_out, 2'b11);
    check("carry_101_cout", bus.carry_out, 1'b0);
`endif
    set_in(4'b1011, 1'b0);
`ifdef LOGIC_CELL_CARRY_EN
    check("carry_110_out", bus.data_out, 2'b00);
    check("carry_110_cout", bus.carry_out, 1'b1);
`else
    check("carry_110_out", bus.data_out, 2'b00);
    check("carry_110_cout", bus.carry_out, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fracturable_logic_cell.md
FRACTURABLE_LOGIC_CELL -- requirements
Module: fracturable_logic_cell

Interface
REQ-001 Parameter K, default 4: LUT input count; legal range 2..6.
REQ-002 Parameter CFG_W, default 2**K+5: configuration frame width; derived, not overridden.
REQ-003 clock  input  1  clock; all state updates on the rising edge.
REQ-004 nreset  input  1  synchronous, active-low reset.
REQ-005 enable  input  1  user flip-flop clock enable.
REQ-006 data_in  input  K  LUT inputs.
REQ-007 data_out  output  2  cell outputs; bit 0 = output A, bit 1 = output B.
REQ-008 carry_in  input  1  carry from the neighbouring cell.
REQ-009 carry_out  output  1  carry to the next cell.
REQ-010 cfg_shift  input  1  shift one bit of the serial config chain.
REQ-011 cfg_in  input  1  serial config data in.
REQ-012 cfg_out  output  1  serial config data out; equals shadow[0].
REQ-013 cfg_commit  input  1  copy the shadow frame into the active config.

Function
REQ-014 Active config fields: truth table T = cfg[2**K-1:0]; FRAC = cfg[2**K]; COMB_A = cfg[2**K+1]; COMB_B = cfg[2**K+2]; INIT = cfg[2**K+3]; CARRY = cfg[2**K+4].
REQ-015 Shift: when cfg_shift=1, shadow <= {cfg_in, shadow[CFG_W-1:1]}, so the frame is loaded LSB first in CFG_W cycles.
REQ-016 Commit: when cfg_commit=1, active <= shadow value from before the edge; same-cycle shifts still update the shadow.
REQ-017 Full mode (FRAC=0): zA = T[data_in]; zB = zA.
REQ-018 Fractured mode (FRAC=1): L = data_in[K-2:0]; zA = lower half of T indexed by L; zB = upper half of T indexed by L; data_in[K-1] is ignored.
REQ-019 Two user FFs qA and qB: on commit, both load INIT of the incoming frame; otherwise, when enable=1, qA <= zA and qB <= zB.
REQ-020 Priority: nreset over cfg_commit over enable.
REQ-021 data_out[0] = COMB_A ? zA : qA; data_out[1] = COMB_B ? zB : qB.
REQ-022 LUT and output paths are combinational; zero latency from data_in to a comb output.
REQ-023 Registered outputs have one-cycle latency after an enabled edge.
REQ-024 Active config changes only on commit or reset; shifting never disturbs logic behaviour.

Reset
REQ-025 nreset=0 at an edge clears shadow, active config, qA and qB to 0.
REQ-026 After reset: data_out = 2'b00, cfg_out = 0, carry_out = 0.
REQ-027 A reset during a partial frame load discards the partial frame; reloading needs a full CFG_W shifts.

Configuration
REQ-028 Macro LOGIC_CELL_CARRY_EN selects whether the carry chain is built.
REQ-029 With LOGIC_CELL_CARRY_EN defined and CARRY=1, FRAC is treated as 1.
REQ-030 In that mode: p = lower-half output; zA = p XOR carry_in; carry_out = p ? carry_in : data_in[K-1]; zB is unchanged.
REQ-031 In that mode, carry_out is combinational and independent of enable.
REQ-032 Without the macro: the CARRY bit is stored but ignored, carry_out is tied to 0, and carry_in is unused.
REQ-033 Port list and CFG_W are identical in both builds.

Verification
REQ-034 K=4: shift 21 bits (T=16'h8000, COMB_A=1) then commit; data_in=4'hF -> data_out[0]=1; data_in=4'hE -> data_out[0]=0.
REQ-035 Registered path: T=16'hFFFF, COMB_A=0, INIT=0, enable=0 -> data_out[0] stays 0; assert enable for one cycle -> data_out[0]=1 on the next cycle.
REQ-036 Fractured mode: T=16'h00FF, FRAC=1, COMB_A=COMB_B=1, data_in=4'h3 -> data_out=2'b01; data_in=4'hB gives the same result, showing data_in[3] is ignored.
REQ-037 Commit with INIT=1 while enable=1 in the same cycle -> qA=qB=1 (commit wins); pulse nreset -> data_out=0, and cfg_out is 0 for the next 21 shifts of cfg_in=0.
REQ-038 Shift 10 bits, reset, shift a full frame, commit -> only the new frame is active; cfg_out replays shadow bits in order.
REQ-039 With LOGIC_CELL_CARRY_EN, CARRY=1, lower half = XOR of data_in[0] and data_in[1]: for (a,b,cin)=(1,0,1) -> zA=0, carry_out=1; for (1,1,0) with data_in[3]=1 -> zA=0, carry_out=1. Without the macro, carry_out=0 for both.
